// File: rtl/id_stage_pipe.sv
// RV32I integer-ALU decode stage: operand forwarding from EX/MEM, load-use
// stall detection and a registered ID/EX boundary with hold, flush and bubbles.
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       r1_data_i,
    input  logic [XLEN-1:0]       r2_data_i,
    output logic                  r1_enable_o,
    output logic                  r2_enable_o,
    output logic [REG_ADDR_W-1:0] r1_addr_o,
    output logic [REG_ADDR_W-1:0] r2_addr_o,
    input  logic                  ex_w_enable_i,
    input  logic [REG_ADDR_W-1:0] ex_w_addr_i,
    input  logic [XLEN-1:0]       ex_w_data_i,
    input  logic                  ex_is_load_i,
    input  logic                  mem_w_enable_i,
    input  logic [REG_ADDR_W-1:0] mem_w_addr_i,
    input  logic [XLEN-1:0]       mem_w_data_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  ex_valid_o,
    output logic [ALUOP_W-1:0]    aluop_o,
    output logic [ALUSEL_W-1:0]   alusel_o,
    output logic [XLEN-1:0]       r1_data_o,
    output logic [XLEN-1:0]       r2_data_o,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic                  inst_invalid_o
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [ALUOP_W-1:0] EX_NOP_OP  = ALUOP_W'(8'h00);
    localparam logic [ALUOP_W-1:0] EX_ADD_OP  = ALUOP_W'(8'h20);
    localparam logic [ALUOP_W-1:0] EX_SUB_OP  = ALUOP_W'(8'h22);
    localparam logic [ALUOP_W-1:0] EX_AND_OP  = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] EX_OR_OP   = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] EX_XOR_OP  = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] EX_SLT_OP  = ALUOP_W'(8'h2a);
    localparam logic [ALUOP_W-1:0] EX_SLTU_OP = ALUOP_W'(8'h2b);
    localparam logic [ALUOP_W-1:0] EX_SLL_OP  = ALUOP_W'(8'h7c);
    localparam logic [ALUOP_W-1:0] EX_SRL_OP  = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] EX_SRA_OP  = ALUOP_W'(8'h03);

    localparam logic [ALUSEL_W-1:0] EX_RES_NOP   = ALUSEL_W'(3'd0);
    localparam logic [ALUSEL_W-1:0] EX_RES_LOGIC = ALUSEL_W'(3'd1);
    localparam logic [ALUSEL_W-1:0] EX_RES_SHIFT = ALUSEL_W'(3'd2);
    localparam logic [ALUSEL_W-1:0] EX_RES_ARITH = ALUSEL_W'(3'd4);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic signed [11:0]    imm_i12;
    logic signed [31:0]    imm_u32;
    logic [XLEN-1:0]       imm_i;
    logic [XLEN-1:0]       imm_u;
    logic [XLEN-1:0]       shamt;
    logic [XLEN-1:0]       fwd1;
    logic [XLEN-1:0]       fwd2;

    logic                  dec_legal;
    logic                  dec_use1;
    logic                  dec_use2;
    logic [ALUOP_W-1:0]    dec_aluop;
    logic [ALUSEL_W-1:0]   dec_alusel;
    logic [XLEN-1:0]       dec_op1;
    logic [XLEN-1:0]       dec_op2;
    logic                  dec_valid;
    logic                  load_hit;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign funct7  = inst_i[31:25];
    assign rs1     = REG_ADDR_W'(inst_i[19:15]);
    assign rs2     = REG_ADDR_W'(inst_i[24:20]);
    assign rd      = REG_ADDR_W'(inst_i[11:7]);
    assign imm_i12 = inst_i[31:20];
    assign imm_u32 = {inst_i[31:12], 12'b0};
    assign imm_i   = XLEN'(imm_i12);
    assign imm_u   = XLEN'(imm_u32);
    assign shamt   = XLEN'(inst_i[24:20]);

    assign r1_addr_o = rs1;
    assign r2_addr_o = rs2;

    // x0 reads are hard-wired zero; EX results are younger than MEM results.
    assign fwd1 = (rs1 == '0) ? '0 :
                  (ex_w_enable_i  && ex_w_addr_i  == rs1) ? ex_w_data_i  :
                  (mem_w_enable_i && mem_w_addr_i == rs1) ? mem_w_data_i : r1_data_i;
    assign fwd2 = (rs2 == '0) ? '0 :
                  (ex_w_enable_i  && ex_w_addr_i  == rs2) ? ex_w_data_i  :
                  (mem_w_enable_i && mem_w_addr_i == rs2) ? mem_w_data_i : r2_data_i;

    always_comb begin
        dec_legal  = 1'b0;
        dec_use1   = 1'b0;
        dec_use2   = 1'b0;
        dec_aluop  = EX_NOP_OP;
        dec_alusel = EX_RES_NOP;
        dec_op1    = '0;
        dec_op2    = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_legal = 1'b1;
                dec_use1  = 1'b1;
                dec_op1   = fwd1;
                dec_op2   = imm_i;
                case (funct3)
                    3'b000: begin dec_aluop = EX_ADD_OP;  dec_alusel = EX_RES_ARITH; end
                    3'b010: begin dec_aluop = EX_SLT_OP;  dec_alusel = EX_RES_ARITH; end
                    3'b011: begin dec_aluop = EX_SLTU_OP; dec_alusel = EX_RES_ARITH; end
                    3'b100: begin dec_aluop = EX_XOR_OP;  dec_alusel = EX_RES_LOGIC; end
                    3'b110: begin dec_aluop = EX_OR_OP;   dec_alusel = EX_RES_LOGIC; end
                    3'b111: begin dec_aluop = EX_AND_OP;  dec_alusel = EX_RES_LOGIC; end
                    3'b001: begin
                        dec_op2    = shamt;
                        dec_aluop  = EX_SLL_OP;
                        dec_alusel = EX_RES_SHIFT;
                        dec_legal  = (funct7 == F7_BASE);
                    end
                    default: begin
                        dec_op2    = shamt;
                        dec_alusel = EX_RES_SHIFT;
                        dec_aluop  = (funct7 == F7_ALT) ? EX_SRA_OP : EX_SRL_OP;
                        dec_legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
                dec_op1  = fwd1;
                dec_op2  = fwd2;
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  begin dec_aluop = EX_ADD_OP;  dec_alusel = EX_RES_ARITH; end
                        3'b001:  begin dec_aluop = EX_SLL_OP;  dec_alusel = EX_RES_SHIFT; end
                        3'b010:  begin dec_aluop = EX_SLT_OP;  dec_alusel = EX_RES_ARITH; end
                        3'b011:  begin dec_aluop = EX_SLTU_OP; dec_alusel = EX_RES_ARITH; end
                        3'b100:  begin dec_aluop = EX_XOR_OP;  dec_alusel = EX_RES_LOGIC; end
                        3'b101:  begin dec_aluop = EX_SRL_OP;  dec_alusel = EX_RES_SHIFT; end
                        3'b110:  begin dec_aluop = EX_OR_OP;   dec_alusel = EX_RES_LOGIC; end
                        default: begin dec_aluop = EX_AND_OP;  dec_alusel = EX_RES_LOGIC; end
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_aluop  = EX_SUB_OP;
                    dec_alusel = EX_RES_ARITH;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal  = 1'b1;
                    dec_aluop  = EX_SRA_OP;
                    dec_alusel = EX_RES_SHIFT;
                end
            end
            OPC_LUI: begin
                dec_legal  = 1'b1;
                dec_op2    = imm_u;
                dec_aluop  = EX_OR_OP;
                dec_alusel = EX_RES_LOGIC;
            end
            OPC_AUIPC: begin
                dec_legal  = 1'b1;
                dec_op1    = pc_i;
                dec_op2    = imm_u;
                dec_aluop  = EX_ADD_OP;
                dec_alusel = EX_RES_ARITH;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_valid   = if_valid_i && dec_legal;
    assign r1_enable_o = dec_valid && dec_use1;
    assign r2_enable_o = dec_valid && dec_use2;

    // A load in EX has no data yet, so a consumer must wait one cycle.
    assign load_hit = ex_is_load_i && ex_w_enable_i && (ex_w_addr_i != '0) &&
                      ((r1_enable_o && ex_w_addr_i == rs1) ||
                       (r2_enable_o && ex_w_addr_i == rs2));
    assign stall_req_o = if_valid_i && load_hit && !rst && !flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            ex_valid_o     <= 1'b0;
            aluop_o        <= EX_NOP_OP;
            alusel_o       <= EX_RES_NOP;
            r1_data_o      <= '0;
            r2_data_o      <= '0;
            w_enable_o     <= 1'b0;
            w_addr_o       <= '0;
            inst_invalid_o <= 1'b0;
        end else if (stall_i) begin
            inst_invalid_o <= 1'b0;
        end else if (dec_valid && !stall_req_o) begin
            ex_valid_o     <= 1'b1;
            aluop_o        <= dec_aluop;
            alusel_o       <= dec_alusel;
            r1_data_o      <= dec_op1;
            r2_data_o      <= dec_op2;
            w_enable_o     <= 1'b1;
            w_addr_o       <= rd;
            inst_invalid_o <= 1'b0;
        end else begin
            // Load-use bubble, empty slot, or a dropped illegal instruction.
            ex_valid_o     <= 1'b0;
            aluop_o        <= EX_NOP_OP;
            alusel_o       <= EX_RES_NOP;
            r1_data_o      <= '0;
            r2_data_o      <= '0;
            w_enable_o     <= 1'b0;
            w_addr_o       <= '0;
            inst_invalid_o <= if_valid_i && !dec_legal;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed cases then random traffic,
// expected ID/EX contents come from a table-driven reference decoder.
module tb_id_stage_pipe;

    localparam logic [7:0] NOP_OP = 8'h00, ADD_OP = 8'h20, SUB_OP = 8'h22, AND_OP = 8'h24;
    localparam logic [7:0] OR_OP = 8'h25, XOR_OP = 8'h26, SLT_OP = 8'h2a, SLTU_OP = 8'h2b;
    localparam logic [7:0] SLL_OP = 8'h7c, SRL_OP = 8'h02, SRA_OP = 8'h03;
    localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2, RES_ARITH = 3'd4;

    logic        clk = 1'b0;
    logic        rst, if_valid_i, stall_i, flush_i;
    logic [31:0] pc_i, inst_i, r1_data_i, r2_data_i;
    logic        r1_enable_o, r2_enable_o, stall_req_o;
    logic [4:0]  r1_addr_o, r2_addr_o;
    logic        ex_w_enable_i, ex_is_load_i, mem_w_enable_i;
    logic [4:0]  ex_w_addr_i, mem_w_addr_i;
    logic [31:0] ex_w_data_i, mem_w_data_i;
    logic        ex_valid_o, w_enable_o, inst_invalid_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] r1_data_o, r2_data_o;
    logic [4:0]  w_addr_o;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
        .r1_enable_o(r1_enable_o), .r2_enable_o(r2_enable_o),
        .r1_addr_o(r1_addr_o), .r2_addr_o(r2_addr_o),
        .ex_w_enable_i(ex_w_enable_i), .ex_w_addr_i(ex_w_addr_i), .ex_w_data_i(ex_w_data_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_w_enable_i(mem_w_enable_i), .mem_w_addr_i(mem_w_addr_i), .mem_w_data_i(mem_w_data_i),
        .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
        .ex_valid_o(ex_valid_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .r1_data_o(r1_data_o), .r2_data_o(r2_data_o),
        .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .inst_invalid_o(inst_invalid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, flush, stall, ifv;
        logic [31:0] pc, inst, r1d, r2d;
        bit exwe, exld, memwe;
        logic [4:0] exwa, memwa;
        logic [31:0] exd, memd;
    } stim_t;

    typedef struct {
        int due;
        bit valid, we, inv;
        logic [7:0] op;
        logic [2:0] sel;
        logic [31:0] r1, r2;
        logic [4:0] wa;
    } exp_t;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        bit chk3;
        logic [6:0] f7;
        bit chk7;
        logic [7:0] op;
        logic [2:0] sel;
        int kind;
    } rule_t;

    rule_t rules[$];
    exp_t  sb[$];
    exp_t  cur;
    exp_t  mon_e;
    int    cycle = 0;
    int    compared = 0;
    int    mismatched = 0;

    function automatic void add_rule(input logic [6:0] opc, input logic [2:0] f3, input bit chk3,
                                     input logic [6:0] f7, input bit chk7, input logic [7:0] op,
                                     input logic [2:0] sel, input int kind);
        rule_t r;
        r.opc = opc; r.f3 = f3; r.chk3 = chk3; r.f7 = f7; r.chk7 = chk7;
        r.op = op; r.sel = sel; r.kind = kind;
        rules.push_back(r);
    endfunction

    // kind: 1 reg+imm, 2 reg+shamt, 3 reg+reg, 4 LUI, 5 AUIPC
    function automatic void init_rules();
        add_rule(7'h13, 3'd0, 1, 7'h00, 0, ADD_OP,  RES_ARITH, 1);
        add_rule(7'h13, 3'd2, 1, 7'h00, 0, SLT_OP,  RES_ARITH, 1);
        add_rule(7'h13, 3'd3, 1, 7'h00, 0, SLTU_OP, RES_ARITH, 1);
        add_rule(7'h13, 3'd4, 1, 7'h00, 0, XOR_OP,  RES_LOGIC, 1);
        add_rule(7'h13, 3'd6, 1, 7'h00, 0, OR_OP,   RES_LOGIC, 1);
        add_rule(7'h13, 3'd7, 1, 7'h00, 0, AND_OP,  RES_LOGIC, 1);
        add_rule(7'h13, 3'd1, 1, 7'h00, 1, SLL_OP,  RES_SHIFT, 2);
        add_rule(7'h13, 3'd5, 1, 7'h00, 1, SRL_OP,  RES_SHIFT, 2);
        add_rule(7'h13, 3'd5, 1, 7'h20, 1, SRA_OP,  RES_SHIFT, 2);
        add_rule(7'h33, 3'd0, 1, 7'h00, 1, ADD_OP,  RES_ARITH, 3);
        add_rule(7'h33, 3'd1, 1, 7'h00, 1, SLL_OP,  RES_SHIFT, 3);
        add_rule(7'h33, 3'd2, 1, 7'h00, 1, SLT_OP,  RES_ARITH, 3);
        add_rule(7'h33, 3'd3, 1, 7'h00, 1, SLTU_OP, RES_ARITH, 3);
        add_rule(7'h33, 3'd4, 1, 7'h00, 1, XOR_OP,  RES_LOGIC, 3);
        add_rule(7'h33, 3'd5, 1, 7'h00, 1, SRL_OP,  RES_SHIFT, 3);
        add_rule(7'h33, 3'd6, 1, 7'h00, 1, OR_OP,   RES_LOGIC, 3);
        add_rule(7'h33, 3'd7, 1, 7'h00, 1, AND_OP,  RES_LOGIC, 3);
        add_rule(7'h33, 3'd0, 1, 7'h20, 1, SUB_OP,  RES_ARITH, 3);
        add_rule(7'h33, 3'd5, 1, 7'h20, 1, SRA_OP,  RES_SHIFT, 3);
        add_rule(7'h37, 3'd0, 0, 7'h00, 0, OR_OP,   RES_LOGIC, 4);
        add_rule(7'h17, 3'd0, 0, 7'h00, 0, ADD_OP,  RES_ARITH, 5);
    endfunction

    function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                       output logic [7:0] op, output logic [2:0] sel, output int kind);
        legal = 0; op = NOP_OP; sel = RES_NOP; kind = 0;
        foreach (rules[i]) begin
            if (rules[i].opc == w[6:0] && (!rules[i].chk3 || rules[i].f3 == w[14:12]) &&
                (!rules[i].chk7 || rules[i].f7 == w[31:25])) begin
                legal = 1; op = rules[i].op; sel = rules[i].sel; kind = rules[i].kind;
            end
        end
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] x);
        int v;
        v = int'(x);
        if (v >= 2048) v = v - 4096;
        return 32'(v);
    endfunction

    function automatic logic [31:0] src_value(input logic [4:0] r, input logic [31:0] rf, input stim_t s);
        if (r == 5'd0) return 32'd0;
        if (s.exwe && s.exwa == r) return s.exd;
        if (s.memwe && s.memwa == r) return s.memd;
        return rf;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, opc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s (cycle %0d): actual %h required %h", name, cycle, act, expv);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        bit legal, vd, en1, en2, sreq;
        logic [7:0] op;
        logic [2:0] sel;
        int kind;
        logic [4:0] rs1, rs2;
        exp_t nx;
        @(posedge clk);
        #1;
        rst = s.rst; flush_i = s.flush; stall_i = s.stall; if_valid_i = s.ifv;
        pc_i = s.pc; inst_i = s.inst; r1_data_i = s.r1d; r2_data_i = s.r2d;
        ex_w_enable_i = s.exwe; ex_w_addr_i = s.exwa; ex_w_data_i = s.exd; ex_is_load_i = s.exld;
        mem_w_enable_i = s.memwe; mem_w_addr_i = s.memwa; mem_w_data_i = s.memd;

        rs1 = s.inst[19:15];
        rs2 = s.inst[24:20];
        ref_decode(s.inst, legal, op, sel, kind);
        vd   = s.ifv && legal;
        en1  = vd && (kind == 1 || kind == 2 || kind == 3);
        en2  = vd && (kind == 3);
        sreq = s.ifv && !s.rst && !s.flush && s.exld && s.exwe && s.exwa != 5'd0 &&
               ((en1 && s.exwa == rs1) || (en2 && s.exwa == rs2));

        if (s.rst || s.flush) nx = bubble();
        else if (s.stall) begin nx = cur; nx.inv = 0; end
        else if (sreq) nx = bubble();
        else if (vd) begin
            nx = bubble();
            nx.valid = 1; nx.we = 1; nx.op = op; nx.sel = sel; nx.wa = s.inst[11:7];
            case (kind)
                1: begin nx.r1 = src_value(rs1, s.r1d, s); nx.r2 = sext12(s.inst[31:20]); end
                2: begin nx.r1 = src_value(rs1, s.r1d, s); nx.r2 = 32'(s.inst[24:20]); end
                3: begin nx.r1 = src_value(rs1, s.r1d, s); nx.r2 = src_value(rs2, s.r2d, s); end
                4: begin nx.r1 = 32'd0; nx.r2 = s.inst & 32'hFFFFF000; end
                default: begin nx.r1 = s.pc; nx.r2 = s.inst & 32'hFFFFF000; end
            endcase
        end else begin
            nx = bubble();
            nx.inv = s.ifv;
        end
        cur = nx;
        nx.due = cycle + 1;
        sb.push_back(nx);

        #1;
        checkOutput("r1_enable", 32'(r1_enable_o), 32'(en1));
        checkOutput("r2_enable", 32'(r2_enable_o), 32'(en2));
        checkOutput("r1_addr", 32'(r1_addr_o), 32'(rs1));
        checkOutput("r2_addr", 32'(r2_addr_o), 32'(rs2));
        checkOutput("stall_req", 32'(stall_req_o), 32'(sreq));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            #3;
            if (sb.size() > 0 && sb[0].due == cycle) begin
                mon_e = sb.pop_front();
                checkOutput("ex_valid", 32'(ex_valid_o), 32'(mon_e.valid));
                checkOutput("aluop", 32'(aluop_o), 32'(mon_e.op));
                checkOutput("alusel", 32'(alusel_o), 32'(mon_e.sel));
                checkOutput("r1_data", r1_data_o, mon_e.r1);
                checkOutput("r2_data", r2_data_o, mon_e.r2);
                checkOutput("w_enable", 32'(w_enable_o), 32'(mon_e.we));
                checkOutput("w_addr", 32'(w_addr_o), 32'(mon_e.wa));
                checkOutput("inst_invalid", 32'(inst_invalid_o), 32'(mon_e.inv));
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd, ra, rb;
        f3 = 3'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       f7 = 7'h20;
            1:       f7 = 7'($urandom);
            default: f7 = 7'h00;
        endcase
        case ($urandom_range(0, 9))
            0, 1:    return enc_i(3'($urandom_range(2, 7)) | 3'b010, rd, ra, 12'($urandom));
            2:       return {f7, rb, ra, ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1, rd, 7'h13};
            3, 4, 5: return enc_r(f7, f3, rd, ra, rb);
            6:       return enc_u(7'h37, rd, 20'($urandom));
            7:       return enc_u(7'h17, rd, 20'($urandom));
            8:       return $urandom;
            default: return enc_i(f3, rd, ra, 12'($urandom));
        endcase
    endfunction

    stim_t s;

    initial begin
        init_rules();
        cur = bubble();
        s = idle();
        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; if_valid_i = 1'b0;
        pc_i = '0; inst_i = '0; r1_data_i = '0; r2_data_i = '0;
        ex_w_enable_i = 1'b0; ex_w_addr_i = '0; ex_w_data_i = '0; ex_is_load_i = 1'b0;
        mem_w_enable_i = 1'b0; mem_w_addr_i = '0; mem_w_data_i = '0;

        // reset with ORI x1,x0,0x7FF presented, then release
        s.rst = 1; s.ifv = 1; s.inst = enc_i(3'd6, 5'd1, 5'd0, 12'h7FF);
        applyStimulus(s);
        applyStimulus(s);
        s.rst = 0;
        applyStimulus(s);

        // immediates
        s = idle(); s.ifv = 1; s.inst = enc_i(3'd0, 5'd2, 5'd3, 12'hFFF); s.r1d = 32'd5;
        applyStimulus(s);
        s.inst = enc_u(7'h37, 5'd4, 20'h80000);
        applyStimulus(s);
        s.inst = enc_u(7'h17, 5'd9, 20'h00001); s.pc = 32'h100;
        applyStimulus(s);

        // forwarding priority and x0
        s = idle(); s.ifv = 1; s.inst = enc_r(7'h00, 3'd0, 5'd5, 5'd6, 5'd6);
        s.exwe = 1; s.exwa = 5'd6; s.exd = 32'hAA;
        s.memwe = 1; s.memwa = 5'd6; s.memd = 32'hBB;
        s.r1d = 32'hCC; s.r2d = 32'hCC;
        applyStimulus(s);
        s.exwe = 0;
        applyStimulus(s);
        s.inst = enc_r(7'h00, 3'd0, 5'd11, 5'd0, 5'd0);
        s.exwe = 1; s.exwa = 5'd0; s.exd = 32'h55; s.memwa = 5'd0; s.r1d = 32'h77; s.r2d = 32'h77;
        applyStimulus(s);

        // load-use bubble, then MEM forward
        s = idle(); s.ifv = 1; s.inst = enc_r(7'h00, 3'd0, 5'd8, 5'd7, 5'd1);
        s.exld = 1; s.exwe = 1; s.exwa = 5'd7; s.exd = 32'hDEAD; s.r2d = 32'd3;
        applyStimulus(s);
        s.exld = 0; s.exwe = 0; s.memwe = 1; s.memwa = 5'd7; s.memd = 32'h12;
        applyStimulus(s);

        // hold for three cycles, then flush wins over stall
        s = idle(); s.ifv = 1; s.inst = enc_i(3'd6, 5'd12, 5'd0, 12'h123);
        applyStimulus(s);
        s.stall = 1; s.inst = enc_i(3'd4, 5'd13, 5'd0, 12'h456);
        repeat (3) applyStimulus(s);
        s.flush = 1;
        applyStimulus(s);

        // illegal instructions, then a legal one clears the flag
        s = idle(); s.ifv = 1; s.inst = 32'hFFFFFFFF;
        applyStimulus(s);
        s.inst = enc_r(7'h20, 3'd6, 5'd1, 5'd2, 5'd3);
        applyStimulus(s);
        s.inst = enc_i(3'd0, 5'd1, 5'd0, 12'd7);
        applyStimulus(s);
        s.inst = 32'hFFFFFFFF;
        applyStimulus(s);
        s.stall = 1; s.inst = enc_i(3'd0, 5'd1, 5'd0, 12'd9);
        applyStimulus(s);

        // reset during a load-use condition
        s = idle(); s.ifv = 1; s.rst = 1; s.inst = enc_r(7'h00, 3'd0, 5'd8, 5'd7, 5'd1);
        s.exld = 1; s.exwe = 1; s.exwa = 5'd7;
        applyStimulus(s);

        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 49) == 0);
            s.flush = ($urandom_range(0, 15) == 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.ifv   = ($urandom_range(0, 7) != 0);
            s.pc    = $urandom & 32'hFFFFFFFC;
            s.inst  = rand_inst();
            s.r1d   = $urandom;
            s.r2d   = $urandom;
            s.exwe  = ($urandom_range(0, 1) != 0);
            s.exwa  = 5'($urandom_range(0, 7));
            s.exd   = $urandom;
            s.exld  = ($urandom_range(0, 3) == 0);
            s.memwe = ($urandom_range(0, 1) != 0);
            s.memwa = 5'($urandom_range(0, 7));
            s.memd  = $urandom;
            applyStimulus(s);
        end

        s = idle();
        applyStimulus(s);
        applyStimulus(s);
        repeat (2) @(posedge clk);
        #5;
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
